mnist_image_feeder: RTL and testbench
=====================================

Name: mnist_image_feeder

Overview:
- Host-side initiator for the 10-neuron classification layer.
- Buffers one 784-pixel image written by the host, then on `go` drives the layer's `start`/`d_in` stream.
- Captures the 4-bit prediction when the layer signals done and returns it to the host over a valid/ready result handshake.
- Sits between the host/DMA write port and the classification layer; one image in flight at a time.

Parameters:
- NUM_PIXELS, 784, pixels per image and stream length in cycles.
- DATA_W, 16, signed pixel width; matches the layer's `d_in`.
- ADDR_W, 10, pixel buffer address width; must satisfy 2**ADDR_W >= NUM_PIXELS.
- TIMEOUT_CYCLES, 4096, max cycles to wait for a layer-done rising edge after the last pixel.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- wr_en  in  1  host pixel write strobe.
- wr_addr  in  ADDR_W  pixel index, 0..NUM_PIXELS-1.
- wr_data  in  DATA_W  signed pixel value.
- go  in  1  start classification of the buffered image.
- busy  out  1  high in every state except IDLE.
- layer_start  out  1  one-cycle start pulse to the layer.
- layer_d_in  out  DATA_W  signed pixel stream to the layer.
- layer_prediction  in  4  argmax index from the layer.
- layer_done  in  1  layer completion; level signal, may remain high between images.
- result_valid  out  1  result available.
- result_ready  in  1  host accepts result.
- result_digit  out  4  captured prediction; 4'hF on timeout.
- result_timeout  out  1  result was produced by the timeout path.

Behaviour:
- One clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: busy=0, layer_start=0, layer_d_in=0, result_valid=0, result_digit=0, result_timeout=0, state=IDLE, counters=0, registered layer_done=0.
- The pixel buffer is not reset; its contents survive reset as-is.
- Pixel buffer:
  - NUM_PIXELS x DATA_W, synchronous write.
  - A write is accepted only when wr_en=1, state=IDLE and wr_addr<NUM_PIXELS. All other writes are silently dropped.
- States: IDLE -> STREAM -> WAIT_DONE -> RESULT -> IDLE.
- IDLE:
  - go=1 moves to STREAM at the next edge.
  - go is ignored in every other state.
  - If wr_en and go are high in the same cycle, the write completes first and is visible to the stream.
- STREAM:
  - If go is sampled in cycle T, then layer_start=1 and layer_d_in=pixel[0] in cycle T+1.
  - pixel[k] is driven in cycle T+1+k. The last pixel is in cycle T+NUM_PIXELS.
  - layer_start is high only in cycle T+1.
  - layer_d_in=0 in every cycle outside the stream window.
  - The stream has no gaps and no backpressure.
  - The read path prefetches so that pixel[0] is valid coincident with start.
- WAIT_DONE:
  - Entered in the cycle after the last pixel.
  - Completion requires a rising edge of layer_done (layer_done=1 with the previous-cycle sample =0). A level held high from a prior image does not complete.
  - The edge detector runs in all states. A rising edge seen during STREAM is ignored.
  - On the edge: capture layer_prediction into result_digit, set result_timeout=0, go to RESULT.
  - If the cycle counter reaches TIMEOUT_CYCLES with no edge: result_digit=4'hF, result_timeout=1, go to RESULT.
- RESULT:
  - result_valid=1, with result_digit and result_timeout held stable.
  - When result_valid and result_ready are both high, return to IDLE next cycle and clear result_valid.
  - result_ready while result_valid=0 has no effect.
- busy=1 in STREAM, WAIT_DONE and RESULT.
- Reset mid-operation: immediate return to reset values. No partial stream resumes. A new go is needed after reset release.
- No arithmetic on pixel data; values pass through bit-exact, sign preserved.

Test Plan:
- Write pixel[i]=i-392 for all i, pulse go at cycle 10 -> layer_start high only at cycle 11; layer_d_in=-392 at 11, 391 at 794; 0 at 795; busy high from 11.
- Stream as above, layer model raises layer_done 20 cycles after the last pixel with prediction=7, result_ready=0 for 5 cycles then 1 -> result_valid high 5+ cycles with digit=7, timeout=0; IDLE and busy=0 the cycle after the handshake.
- layer_done held high from the previous image through the new stream, never toggling -> after TIMEOUT_CYCLES result_digit=4'hF, result_timeout=1.
- Writes during busy (addr 5, data 0x7FFF) and a write to addr 800 in IDLE -> next stream shows pixel[5] unchanged; no corruption of any location.
- Assert rst_n=0 at stream pixel 300 -> all outputs 0 in the same cycle; after release, go restarts from pixel[0] with the buffer contents intact.
- go pulsed again in WAIT_DONE and RESULT -> ignored; exactly one start pulse per accepted go.

Source files
------------

// File: rtl/mnist_image_feeder.sv
// rtl/mnist_image_feeder.sv - image buffer and stream initiator for the 10-neuron classification layer
//
// Purpose:
//    Holds one NUM_PIXELS image written by the host. On go, streams it to the
//    classification layer as a start pulse plus one pixel per cycle. It then waits
//    for a rising edge on layer_done, or gives up after TIMEOUT_CYCLES. The captured
//    digit is returned to the host over a valid/ready handshake.
//
// Ports:
//    clk, rst_n         clock, asynchronous active-low reset
//    wr_en/addr/data    host pixel write port, accepted only while idle
//    go                 start classification of the buffered image (idle only)
//    busy               high whenever not idle
//    layer_start        one-cycle start pulse, coincident with pixel[0]
//    layer_d_in         pixel stream; zero outside the stream window
//    layer_prediction   argmax index from the layer
//    layer_done         layer completion level; only its rising edge counts
//    result_valid/ready result handshake
//    result_digit       captured prediction, 4'hF on timeout
//    result_timeout     result came from the timeout path

module mnist_image_feeder #(
   parameter int NUM_PIXELS     = 784,
   parameter int DATA_W         = 16,
   parameter int ADDR_W         = 10,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              go,
   output logic              busy,
   output logic              layer_start,
   output logic [DATA_W-1:0] layer_d_in,
   input  logic [3:0]        layer_prediction,
   input  logic              layer_done,
   output logic              result_valid,
   input  logic              result_ready,
   output logic [3:0]        result_digit,
   output logic              result_timeout
);

   localparam int CNT_W = ADDR_W + 1;
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [CNT_W-1:0] PIX_TOTAL = CNT_W'(NUM_PIXELS);
   localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_STREAM    = 2'd1,
      S_WAIT_DONE = 2'd2,
      S_RESULT    = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [DATA_W-1:0] pix_mem [0:NUM_PIXELS-1];

   logic [CNT_W-1:0]  pix_cnt;
   logic [TO_W-1:0]   wait_cnt;
   logic              done_q;
   logic              done_rise;
   logic              wr_ok;
   logic              stream_end;
   logic              timeout_hit;
   logic [DATA_W-1:0] pix0;

   assign wr_ok       = wr_en && (state == S_IDLE) && ({1'b0, wr_addr} < PIX_TOTAL);
   assign done_rise   = layer_done && !done_q;
   // pix_cnt holds the index of the next pixel to load; reaching the total means the last one is on the bus.
   assign stream_end  = (pix_cnt == PIX_TOTAL);
   assign timeout_hit = (wait_cnt == TO_LAST);

   // A write to pixel 0 in the same cycle as go must reach the first streamed word.
   assign pix0 = (wr_ok && (wr_addr == '0)) ? wr_data : pix_mem[0];

   assign busy         = (state != S_IDLE);
   assign result_valid = (state == S_RESULT);

   // Pixel buffer: no reset, contents survive rst_n.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         pix_mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (go) state_nxt = S_STREAM;
         end
         S_STREAM: begin
            if (stream_end) state_nxt = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (done_rise || timeout_hit) state_nxt = S_RESULT;
         end
         S_RESULT: begin
            if (result_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q         <= 1'b0;
         layer_start    <= 1'b0;
         layer_d_in     <= '0;
         pix_cnt        <= '0;
         wait_cnt       <= '0;
         result_digit   <= 4'h0;
         result_timeout <= 1'b0;
      end else begin
         // Edge detector runs in every state; only WAIT_DONE acts on it.
         done_q      <= layer_done;
         layer_start <= 1'b0;
         layer_d_in  <= '0;
         case (state)
            S_IDLE: begin
               if (go) begin
                  layer_start <= 1'b1;
                  layer_d_in  <= pix0;
                  pix_cnt     <= CNT_W'(1);
               end
            end
            S_STREAM: begin
               if (!stream_end) begin
                  layer_d_in <= pix_mem[pix_cnt[ADDR_W-1:0]];
                  pix_cnt    <= pix_cnt + CNT_W'(1);
               end else begin
                  wait_cnt <= '0;
               end
            end
            S_WAIT_DONE: begin
               if (done_rise) begin
                  result_digit   <= layer_prediction;
                  result_timeout <= 1'b0;
               end else if (timeout_hit) begin
                  result_digit   <= 4'hF;
                  result_timeout <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + TO_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mnist_image_feeder.sv
// tb/tb_mnist_image_feeder.sv - directed self-checking bench for mnist_image_feeder

module tb_mnist_image_feeder;

   localparam int NPIX = 784;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en;
   logic [9:0]  wr_addr;
   logic [15:0] wr_data;
   logic        go;
   logic        busy;
   logic        layer_start;
   logic [15:0] layer_d_in;
   logic [3:0]  layer_prediction;
   logic        layer_done;
   logic        result_valid;
   logic        result_ready;
   logic [3:0]  result_digit;
   logic        result_timeout;

   logic [15:0] exp_mem [0:NPIX-1];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          start_cnt = 0;
   int          wait_n;

   mnist_image_feeder dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .wr_en            (wr_en),
      .wr_addr          (wr_addr),
      .wr_data          (wr_data),
      .go               (go),
      .busy             (busy),
      .layer_start      (layer_start),
      .layer_d_in       (layer_d_in),
      .layer_prediction (layer_prediction),
      .layer_done       (layer_done),
      .result_valid     (result_valid),
      .result_ready     (result_ready),
      .result_digit     (result_digit),
      .result_timeout   (result_timeout)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (layer_start) start_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Caller has go (and possibly a write) set in the current cycle.
   // Returns in the first cycle after the last pixel (WAIT_DONE entry).
   task automatic run_stream(input int wr_at);
      tick;
      go    = 1'b0;
      wr_en = 1'b0;
      check("start_t1", layer_start, 1);
      check("pix0", layer_d_in, exp_mem[0]);
      check("busy_t1", busy, 1);
      for (int k = 1; k < NPIX; k++) begin
         tick;
         wr_en = 1'b0;
         if (k == 1) check("start_t2", layer_start, 0);
         check($sformatf("pix%0d", k), layer_d_in, exp_mem[k]);
         if (k == wr_at) begin
            wr_en   = 1'b1;
            wr_addr = 10'd5;
            wr_data = 16'h7FFF;
         end
      end
      tick;
      check("d_in_after", layer_d_in, 0);
      check("busy_wait", busy, 1);
   endtask

   initial begin
      rst_n = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0; go = 1'b0;
      layer_prediction = 4'd0; layer_done = 1'b0; result_ready = 1'b0;
      repeat (3) tick;
      check("rst_busy", busy, 0);
      check("rst_start", layer_start, 0);
      check("rst_d_in", layer_d_in, 0);
      check("rst_valid", result_valid, 0);
      check("rst_digit", result_digit, 0);
      check("rst_tmo", result_timeout, 0);
      rst_n = 1'b1;
      tick;

      // Fill the image: pixel[i] = i - 392
      for (int i = 0; i < NPIX; i++) begin
         exp_mem[i] = 16'(i - 392);
         wr_en   = 1'b1;
         wr_addr = 10'(i);
         wr_data = 16'(i - 392);
         tick;
      end
      wr_en = 1'b0;
      tick;

      // Image 1: done rises 20 cycles after last pixel, prediction 7
      check("exp_first", exp_mem[0], 16'hFE78);
      go = 1'b1;
      run_stream(-1);
      for (int j = 0; j < 19; j++) begin
         go = (j == 5);
         tick;
      end
      go = 1'b0;
      layer_done = 1'b1;
      layer_prediction = 4'd7;
      tick;
      check("r1_valid", result_valid, 1);
      for (int m = 0; m < 5; m++) begin
         go = (m == 2);
         tick;
         check("r1_hold_valid", result_valid, 1);
         check("r1_digit", result_digit, 7);
         check("r1_tmo", result_timeout, 0);
      end
      go = 1'b0;
      result_ready = 1'b1;
      tick;
      result_ready = 1'b0;
      check("r1_idle_busy", busy, 0);
      check("r1_idle_valid", result_valid, 0);
      check("r1_starts", start_cnt, 1);

      // Image 2: out-of-range write in idle, write during busy, done stuck high -> timeout
      wr_en = 1'b1; wr_addr = 10'd800; wr_data = 16'h5555;
      tick;
      wr_en = 1'b0;
      go = 1'b1;
      run_stream(2);
      wait_n = 0;
      while (!result_valid && wait_n < 5000) begin
         tick;
         wait_n++;
      end
      check("tmo_latency", wait_n, 4096);
      check("tmo_digit", result_digit, 4'hF);
      check("tmo_flag", result_timeout, 1);
      go = 1'b1;
      tick;
      go = 1'b0;
      check("tmo_go_ignored", result_valid, 1);
      result_ready = 1'b1;
      tick;
      result_ready = 1'b0;
      check("tmo_idle", busy, 0);
      check("tmo_starts", start_cnt, 2);

      // Image 3: reset at pixel 300
      go = 1'b1;
      tick;
      go = 1'b0;
      repeat (300) tick;
      check("pre_rst_pix300", layer_d_in, exp_mem[300]);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_start", layer_start, 0);
      check("mid_rst_d_in", layer_d_in, 0);
      check("mid_rst_valid", result_valid, 0);
      check("mid_rst_digit", result_digit, 0);
      check("mid_rst_tmo", result_timeout, 0);
      tick;
      tick;
      rst_n = 1'b1;
      repeat (3) tick;
      check("post_rst_busy", busy, 0);
      check("post_rst_starts", start_cnt, 3);

      // Image 4: write pixel 0 together with go, done edge -> digit 3
      wr_en = 1'b1; wr_addr = 10'd0; wr_data = 16'h1234; go = 1'b1;
      exp_mem[0] = 16'h1234;
      run_stream(-1);
      layer_done = 1'b0;
      tick;
      tick;
      layer_done = 1'b1;
      layer_prediction = 4'd3;
      tick;
      check("r4_valid", result_valid, 1);
      check("r4_digit", result_digit, 3);
      check("r4_tmo", result_timeout, 0);
      result_ready = 1'b1;
      tick;
      result_ready = 1'b0;
      check("r4_idle", busy, 0);
      check("r4_starts", start_cnt, 4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
